// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle for the universal shift register.
// The master side drives the operation request; the slave side is the register.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             en;
  logic             start;
  logic             abort;
  logic [2:0]       mode;
  logic [CNTW-1:0]  amt;
  logic [WIDTH-1:0] din;
  logic             sir;
  logic             sil;
  logic [WIDTH-1:0] q;
  logic             sor;
  logic             sol;
  logic             busy;
  logic             done;

  modport master (
    output en, start, abort, mode, amt, din, sir, sil,
    input  q, sor, sol, busy, done
  );

  modport slave (
    input  en, start, abort, mode, amt, din, sir, sil,
    output q, sor, sol, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle operations on en, multi-step shift
// runs on start with a step counter, abort and a one-cycle done pulse.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  univ_shift_reg_if.slave bus
);

  typedef enum logic { IDLE, RUN } state_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SR   = 3'b010,
    OP_SL   = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [2:0]       cmode, cmode_n;
  logic             done_r, done_n;
  logic             run_mode;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] d,
    input logic             r,
    input logic             l
  );
    logic [WIDTH-1:0] res;
    case (op_t'(op))
      OP_HOLD: res = v;
      OP_LOAD: res = d;
      OP_SR:   res = {r, v[WIDTH-1:1]};
      OP_SL:   res = {v[WIDTH-2:0], l};
      OP_ROR:  res = {v[0], v[WIDTH-1:1]};
      OP_ROL:  res = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  res = {v[WIDTH-1], v[WIDTH-1:1]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Only the shift/rotate modes become multi-step runs; hold/load/clear execute once.
  assign run_mode = (bus.mode >= OP_SR) && (bus.mode <= OP_ASR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q_r    <= '0;
      cnt    <= '0;
      cmode  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      cnt    <= cnt_n;
      cmode  <= cmode_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q_r;
    cnt_n   = cnt;
    cmode_n = cmode;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!run_mode) begin
            q_n    = apply_op(bus.mode, q_r, bus.din, bus.sir, bus.sil);
            done_n = 1'b1;
          end else if (bus.amt == '0) begin
            done_n = 1'b1;
          end else begin
            cmode_n = bus.mode;
            cnt_n   = bus.amt;
            state_n = RUN;
          end
        end else if (bus.en) begin
          q_n = apply_op(bus.mode, q_r, bus.din, bus.sir, bus.sil);
        end
      end
      RUN: begin
        if (bus.abort) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          q_n   = apply_op(cmode, q_r, bus.din, bus.sir, bus.sil);
          cnt_n = cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.q    = q_r;
  assign bus.sor  = q_r[0];
  assign bus.sol  = q_r[WIDTH-1];
  assign bus.busy = (state == RUN);
  assign bus.done = done_r;

endmodule
